// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one SP256K between ports A and B.
// Define SPRAM_ARB_PWR_EN to enable the idle standby/wake power manager.
module spram_arbiter #(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [13:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [13:0] ram_ad,
  output logic [15:0] ram_di,
  output logic [3:0]  ram_maskwe,
  output logic        ram_we,
  output logic        ram_cs,
  output logic        ram_stdby,
  output logic        ram_sleep,
  output logic        ram_pwroff_n,
  input  logic [15:0] ram_do
);

  if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_param_check
    $error("spram_arbiter: IDLE_CYCLES and WAKE_CYCLES must be >= 1");
  end

  logic run_en;
  logic grant_a;
  logic grant_b;
  logic last_b;
  logic a_rvalid_q;
  logic b_rvalid_q;

`ifdef SPRAM_ARB_PWR_EN
  localparam int unsigned CntMax = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StRun, StStby, StWake} state_e;

  state_e          state_q;
  logic [CntW-1:0] idle_cnt_q;
  logic [CntW-1:0] wake_cnt_q;
  logic            stdby_q;
  logic            any_req;

  assign any_req = a_req | b_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      stdby_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (any_req) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == CntW'(IDLE_CYCLES - 1)) begin
            state_q    <= StStby;
            idle_cnt_q <= '0;
            stdby_q    <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
          end
        end
        StStby: begin
          if (any_req) begin
            state_q    <= StWake;
            wake_cnt_q <= CntW'(WAKE_CYCLES);
            stdby_q    <= 1'b0;
          end
        end
        StWake: begin
          // The cycle the wake count hits zero already grants, so leave for RUN now.
          if (wake_cnt_q == '0) begin
            state_q    <= StRun;
            idle_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q - CntW'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign run_en    = !rst && ((state_q == StRun) || (state_q == StWake && wake_cnt_q == '0));
  assign ram_stdby = stdby_q;
`else
  assign run_en    = !rst;
  assign ram_stdby = 1'b0;
`endif

  // On a tie, A wins unless A was the most recent grant.
  assign grant_a = run_en & a_req & (~b_req | last_b);
  assign grant_b = run_en & b_req & ~grant_a;

  always_comb begin
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_maskwe = 4'b0000;
    ram_ad     = '0;
    ram_di     = '0;
    if (grant_a) begin
      ram_cs     = 1'b1;
      ram_we     = a_we;
      ram_ad     = a_addr;
      ram_di     = a_wdata;
      ram_maskwe = a_we ? {a_be[1], a_be[1], a_be[0], a_be[0]} : 4'b0000;
    end else if (grant_b) begin
      ram_cs     = 1'b1;
      ram_we     = b_we;
      ram_ad     = b_addr;
      ram_di     = b_wdata;
      ram_maskwe = b_we ? {b_be[1], b_be[1], b_be[0], b_be[0]} : 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b     <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      if (grant_a | grant_b) begin
        last_b <= grant_b;
      end
      a_rvalid_q <= grant_a & ~a_we;
      b_rvalid_q <= grant_b & ~b_we;
    end
  end

  assign a_ack        = grant_a;
  assign b_ack        = grant_b;
  assign a_rvalid     = a_rvalid_q;
  assign b_rvalid     = b_rvalid_q;
  assign a_rdata      = ram_do;
  assign b_rdata      = ram_do;
  assign ram_sleep    = 1'b0;
  assign ram_pwroff_n = 1'b1;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: SP256K behavioural RAM, transaction-level reference model,
// directed cases with literal expectations, then randomized two-port traffic.
module tb_spram_arbiter;
  localparam int unsigned IdleCycles = 4;
  localparam int unsigned WakeCycles = 2;
`ifdef SPRAM_ARB_PWR_EN
  localparam bit Pwr = 1'b1;
`else
  localparam bit Pwr = 1'b0;
`endif

  logic        clk, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic [1:0]  a_be, b_be;
  logic        a_ack, b_ack, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [13:0] ram_ad;
  logic [15:0] ram_di, ram_do;
  logic [3:0]  ram_maskwe;
  logic        ram_we, ram_cs, ram_stdby, ram_sleep, ram_pwroff_n;

  spram_arbiter #(
    .IDLE_CYCLES(IdleCycles),
    .WAKE_CYCLES(WakeCycles)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_maskwe(ram_maskwe), .ram_we(ram_we),
    .ram_cs(ram_cs), .ram_stdby(ram_stdby), .ram_sleep(ram_sleep),
    .ram_pwroff_n(ram_pwroff_n), .ram_do(ram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural SP256K; command sampled mid-cycle, applied at the rising edge.
  logic [15:0] mem [0:16383];
  initial begin
    logic        s_cs, s_we;
    logic [13:0] s_ad;
    logic [15:0] s_di, w;
    logic [3:0]  s_mask;
    for (int i = 0; i < 16384; i++) mem[i] = 16'hC000 | 16'(i);
    ram_do = '0;
    forever begin
      @(negedge clk);
      s_cs = ram_cs; s_we = ram_we; s_ad = ram_ad; s_di = ram_di; s_mask = ram_maskwe;
      @(posedge clk);
      if (s_cs) begin
        if (s_we) begin
          w = mem[s_ad];
          for (int k = 0; k < 4; k++) if (s_mask[k]) w[4*k +: 4] = s_di[4*k +: 4];
          mem[s_ad] = w;
        end else begin
          ram_do <= mem[s_ad];
        end
      end
    end
  end

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] shadow [0:16383];
  bit          wa, wb;
  int          last_g;
  bit          e_arv, e_brv;
  logic [15:0] e_ard, e_brd;
  int          pmode, idle_n, wake_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mask_of(input logic we, input logic [1:0] be);
    return we ? {be[1], be[1], be[0], be[0]} : 4'b0000;
  endfunction

  task automatic model_reset();
    last_g = 1; e_arv = 0; e_brv = 0; wa = 0; wb = 0;
    pmode = 0; idle_n = 0; wake_n = 0;
  endtask

  task automatic shadow_write(input logic [13:0] ad, input logic [15:0] d, input logic [1:0] be);
    if (be[0]) shadow[ad][7:0]  = d[7:0];
    if (be[1]) shadow[ad][15:8] = d[15:8];
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic settle();
    bit run;
    @(negedge clk);
    run = (pmode == 0) || (pmode == 2 && wake_n == 0);
    wa  = run && a_req && (!b_req || last_g == 1);
    wb  = run && b_req && !wa;
    check("a_ack", 32'(a_ack), 32'(wa));
    check("b_ack", 32'(b_ack), 32'(wb));
    check("ram_cs", 32'(ram_cs), 32'(wa || wb));
    if (wa) begin
      check("ram_ad_a", 32'(ram_ad), 32'(a_addr));
      check("ram_di_a", 32'(ram_di), 32'(a_wdata));
      check("ram_we_a", 32'(ram_we), 32'(a_we));
      check("ram_mask_a", 32'(ram_maskwe), 32'(mask_of(a_we, a_be)));
    end else if (wb) begin
      check("ram_ad_b", 32'(ram_ad), 32'(b_addr));
      check("ram_di_b", 32'(ram_di), 32'(b_wdata));
      check("ram_we_b", 32'(ram_we), 32'(b_we));
      check("ram_mask_b", 32'(ram_maskwe), 32'(mask_of(b_we, b_be)));
    end else begin
      check("ram_we_idle", 32'(ram_we), 32'd0);
      check("ram_mask_idle", 32'(ram_maskwe), 32'd0);
    end
    check("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    check("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    if (e_arv) check("a_rdata", 32'(a_rdata), 32'(e_ard));
    if (e_brv) check("b_rdata", 32'(b_rdata), 32'(e_brd));
    check("ram_stdby", 32'(ram_stdby), 32'(pmode == 1));
    check("ram_sleep", 32'(ram_sleep), 32'd0);
    check("ram_pwroff_n", 32'(ram_pwroff_n), 32'd1);
  endtask

  // Apply the current cycle's effects to the model, then move past the clock edge.
  task automatic advance();
    bit any;
    any   = a_req || b_req;
    e_arv = wa && !a_we;
    e_brv = wb && !b_we;
    if (e_arv) e_ard = shadow[a_addr];
    if (e_brv) e_brd = shadow[b_addr];
    if (wa) begin
      if (a_we) shadow_write(a_addr, a_wdata, a_be);
      last_g = 0;
    end
    if (wb) begin
      if (b_we) shadow_write(b_addr, b_wdata, b_be);
      last_g = 1;
    end
    if (Pwr) begin
      case (pmode)
        0: begin
          if (any) idle_n = 0;
          else begin
            idle_n++;
            if (idle_n >= int'(IdleCycles)) begin pmode = 1; idle_n = 0; end
          end
        end
        1: if (any) begin pmode = 2; wake_n = int'(WakeCycles); end
        default: begin
          if (wake_n == 0) begin pmode = 0; idle_n = 0; end
          else wake_n--;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string p);
    check({p, "_a_ack"}, 32'(a_ack), 32'd0);
    check({p, "_b_ack"}, 32'(b_ack), 32'd0);
    check({p, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
    check({p, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
    check({p, "_ram_cs"}, 32'(ram_cs), 32'd0);
    check({p, "_ram_we"}, 32'(ram_we), 32'd0);
    check({p, "_ram_maskwe"}, 32'(ram_maskwe), 32'd0);
    check({p, "_ram_stdby"}, 32'(ram_stdby), 32'd0);
    check({p, "_ram_sleep"}, 32'(ram_sleep), 32'd0);
    check({p, "_ram_pwroff_n"}, 32'(ram_pwroff_n), 32'd1);
    check({p, "_ram_ad"}, 32'(ram_ad), 32'd0);
    check({p, "_ram_di"}, 32'(ram_di), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    for (int i = 0; i < 16384; i++) shadow[i] = 16'hC000 | 16'(i);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // A write then read back, zero-latency ack
    a_req = 1; a_we = 1; a_addr = 14'h0010; a_wdata = 16'h1234; a_be = 2'b11;
    settle();
    check("t1_wr_ack", 32'(a_ack), 32'd1);
    check("t1_wr_mask", 32'(ram_maskwe), 32'hF);
    advance();
    a_we = 0;
    settle();
    check("t1_rd_ack", 32'(a_ack), 32'd1);
    advance();
    a_req = 0;
    settle();
    check("t1_rvalid", 32'(a_rvalid), 32'd1);
    check("t1_rdata", 32'(a_rdata), 32'h1234);
    check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    advance();

    // Byte lane write from B
    a_req = 1; a_we = 1; a_addr = 14'h0020; a_wdata = 16'hFFFF; a_be = 2'b11;
    settle(); advance();
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 14'h0020; b_wdata = 16'hAB00; b_be = 2'b10;
    settle();
    check("t2_mask", 32'(ram_maskwe), 32'hC);
    advance();
    b_we = 0;
    settle(); advance();
    b_req = 0;
    settle();
    check("t2_rdata", 32'(b_rdata), 32'hABFF);
    advance();

    // Continuous contention: strict alternation A,B,A,...
    a_req = 1; a_we = 0; a_addr = 14'd3;
    b_req = 1; b_we = 0; b_addr = 14'd7;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("t3_a_ack", 32'(a_ack), 32'(i % 2 == 0));
      check("t3_b_ack", 32'(b_ack), 32'(i % 2 == 1));
      if (i % 2 == 1) check("t3_a_rdata", 32'(a_rdata), 32'hC003);
      if (i > 0 && i % 2 == 0) check("t3_b_rdata", 32'(b_rdata), 32'hC007);
      advance();
    end
    a_req = 0; b_req = 0;
    settle(); advance();

    // A write / B read same address together
    a_req = 1; a_we = 1; a_addr = 14'h0040; a_wdata = 16'h5A5A; a_be = 2'b11;
    b_req = 1; b_we = 0; b_addr = 14'h0040;
    settle();
    check("t4_a_first", 32'(a_ack), 32'd1);
    advance();
    a_req = 0;
    settle();
    check("t4_b_second", 32'(b_ack), 32'd1);
    advance();
    b_req = 0;
    settle();
    check("t4_b_rdata", 32'(b_rdata), 32'h5A5A);
    advance();

    // Reset during a read-ack cycle
    a_req = 1; a_we = 0; a_addr = 14'h0040;
    settle();
    check("t5_ack_before_rst", 32'(a_ack), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("t5_mid");
    model_reset();
    rst = 1'b0;
    settle();
    check("t5_ack_after", 32'(a_ack), 32'd1);
    advance();
    a_req = 0;
    settle();
    check("t5_rdata_after", 32'(a_rdata), 32'h5A5A);
    advance();

`ifdef SPRAM_ARB_PWR_EN
    do_reset();
    repeat (4) begin settle(); advance(); end
    a_req = 1; a_we = 0; a_addr = 14'h0010;
    settle();
    check("t6_stdby", 32'(ram_stdby), 32'd1);
    check("t6_no_ack0", 32'(a_ack), 32'd0);
    advance();
    settle();
    check("t6_wake", 32'(ram_stdby), 32'd0);
    check("t6_no_ack1", 32'(a_ack), 32'd0);
    advance();
    settle();
    check("t6_no_ack2", 32'(a_ack), 32'd0);
    advance();
    settle();
    check("t6_ack3", 32'(a_ack), 32'd1);
    advance();
    a_req = 0;
    settle();
    check("t6_rdata", 32'(a_rdata), 32'h1234);
    advance();
`endif

    // Randomized traffic; each master holds its request until acked
    for (int c = 0; c < 2000; c++) begin
      settle();
      advance();
      if (wa) a_req = 0;
      if (wb) b_req = 0;
      if (!a_req && $urandom_range(0, 99) < 55) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = 14'($urandom_range(0, 31));
        a_wdata = 16'($urandom); a_be = 2'($urandom_range(0, 3));
      end
      if (!b_req && $urandom_range(0, 99) < 55) begin
        b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = 14'($urandom_range(0, 31));
        b_wdata = 16'($urandom); b_be = 2'($urandom_range(0, 3));
      end
    end
    a_req = 0; b_req = 0;
    repeat (2) begin settle(); advance(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
